// File: rtl/tron_types.sv
// Shared Tron types: framebuffer geometry, pixel codes and RGB444 palette helpers.
package tron_types;

   localparam int unsigned FB_W    = 320;
   localparam int unsigned FB_H    = 240;
   localparam int unsigned FB_SIZE = 76800;

   typedef enum logic [1:0] {
      PIX_EMPTY = 2'b00,
      PIX_P1    = 2'b01,
      PIX_P2    = 2'b10,
      PIX_WALL  = 2'b11
   } pix_code_e;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam rgb444_t RGB_BLACK  = '{r: 4'h0, g: 4'h0, b: 4'h0};
   localparam rgb444_t RGB_BORDER = '{r: 4'h8, g: 4'h8, b: 4'h8};

   // Map a framebuffer pixel code to its display colour.
   function automatic rgb444_t pix_to_rgb(logic [1:0] code);
      rgb444_t c;
      c = RGB_BLACK;
      unique case (code)
         PIX_EMPTY: c = '{r: 4'h0, g: 4'h0, b: 4'h0};
         PIX_P1:    c = '{r: 4'h0, g: 4'hF, b: 4'hF};
         PIX_P2:    c = '{r: 4'hF, g: 4'h8, b: 4'h0};
         PIX_WALL:  c = '{r: 4'hF, g: 4'hF, b: 4'hF};
         default:   c = RGB_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-enable divider, h/v counters, raw syncs, active flag and
// frame_start. Syncs are active-low and unregistered; the caller aligns them with RGB.
module vga_timing #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clock,
   input  logic       reset,
   output logic       pix_en_o,
   output logic [9:0] h_o,
   output logic [9:0] v_o,
   output logic       active_o,
   output logic       hsync_raw_o,
   output logic       vsync_raw_o,
   output logic       frame_start_o
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

   localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
   localparam logic [9:0] H_SS    = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SE    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
   localparam logic [9:0] V_SS    = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [PW-1:0] phase_q, phase_d;
   logic [9:0]    h_q, h_d;
   logic [9:0]    v_q, v_d;
   logic          pix_en;

   assign pix_en = (phase_q == '0);

   // Next-state for divider phase and raster counters; counters only move on pix_en.
   always_comb begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      h_d     = h_q;
      v_d     = v_q;
      if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   // Divider and counter state; reset restarts the frame at (0,0).
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q <= '0;
         h_q     <= 10'd0;
         v_q     <= 10'd0;
      end else begin
         phase_q <= phase_d;
         h_q     <= h_d;
         v_q     <= v_d;
      end
   end

   assign pix_en_o      = pix_en;
   assign h_o           = h_q;
   assign v_o           = v_q;
   assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
   assign hsync_raw_o   = !((h_q >= H_SS) && (h_q < H_SE));
   assign vsync_raw_o   = !((v_q >= V_SS) && (v_q < V_SE));
   // Gated with reset so the pulse stays low while the counters are held at (0,0).
   assign frame_start_o = pix_en && (h_q == 10'd0) && (v_q == 10'd0) && !reset;

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: 320x240 pixels doubled onto 640x480 VGA, 2-bit codes mapped
// to RGB444. RGB, blank and syncs share one pixel-period register stage.
// Optional build macro SCANOUT_BORDER_EN paints the outermost framebuffer ring grey.
module vga_scanout
   import tron_types::*;
#(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic        clock,
   input  logic        reset,
   output logic [18:0] ram_address,
   input  logic [1:0]  ram_read_data,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        blank,
   output logic        frame_start
);

   logic       pix_en;
   logic [9:0] h;
   logic [9:0] v;
   logic       active;
   logic       hsync_raw;
   logic       vsync_raw;

   vga_timing #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE),
      .H_FP    (H_FP),
      .H_SYNC  (H_SYNC),
      .H_BP    (H_BP),
      .V_ACTIVE(V_ACTIVE),
      .V_FP    (V_FP),
      .V_SYNC  (V_SYNC),
      .V_BP    (V_BP)
   ) u_timing (
      .clock        (clock),
      .reset        (reset),
      .pix_en_o     (pix_en),
      .h_o          (h),
      .v_o          (v),
      .active_o     (active),
      .hsync_raw_o  (hsync_raw),
      .vsync_raw_o  (vsync_raw),
      .frame_start_o(frame_start)
   );

   logic [8:0]  fx;
   logic [8:0]  fy;
   logic [18:0] fb_addr;
   rgb444_t     pix_rgb;

   assign fx = h[9:1];
   assign fy = v[9:1];

   // 320*fy + fx as 256*fy + 64*fy + fx, all in 19 bits.
   assign fb_addr     = ({10'd0, fy} << 8) + ({10'd0, fy} << 6) + {10'd0, fx};
   assign ram_address = active ? fb_addr : 19'd0;

   // Colour of the pixel currently addressed; RAM data is back by the pix_en clock.
   always_comb begin
      pix_rgb = pix_to_rgb(ram_read_data);
`ifdef SCANOUT_BORDER_EN
      if ((fx == 9'd0) || (fx == 9'(FB_W - 1)) || (fy == 9'd0) || (fy == 9'(FB_H - 1))) begin
         pix_rgb = RGB_BORDER;
      end
`endif
   end

   rgb444_t rgb_q;
   logic    blank_q;
   logic    hsync_q;
   logic    vsync_q;

   // One-pixel alignment stage for colour, blank and syncs.
   always_ff @(posedge clock) begin
      if (reset) begin
         rgb_q   <= RGB_BLACK;
         blank_q <= 1'b1;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else if (pix_en) begin
         rgb_q   <= active ? pix_rgb : RGB_BLACK;
         blank_q <= !active;
         hsync_q <= hsync_raw;
         vsync_q <= vsync_raw;
      end
   end

   assign red   = rgb_q.r;
   assign green = rgb_q.g;
   assign blue  = rgb_q.b;
   assign blank = blank_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout with a shortened vertical raster (12 lines) so whole
// frames fit in a short run. Time t counts negedges from reset release; pixel p
// (p = 800*v + h) has its address sampled at t = 2p and its output at t = 2p + 1.
module tb_vga_scanout;

   localparam int unsigned VA = 6;
   localparam int unsigned VF = 2;
   localparam int unsigned VS = 2;
   localparam int unsigned VB = 2;
   localparam int FRAME_T = 2 * 800 * (VA + VF + VS + VB);  // 19200 clocks

   localparam logic [11:0] C_BLACK  = 12'h000;
   localparam logic [11:0] C_P1     = 12'h0FF;
   localparam logic [11:0] C_P2     = 12'hF80;
   localparam logic [11:0] C_WALL   = 12'hFFF;
   localparam logic [11:0] C_BORDER = 12'h888;
`ifdef SCANOUT_BORDER_EN
   localparam logic [11:0] ROW0_P1 = C_BORDER;
   localparam logic [11:0] ROW0_P2 = C_BORDER;
   localparam logic [11:0] EDGE_C  = C_BORDER;
`else
   localparam logic [11:0] ROW0_P1 = C_P1;
   localparam logic [11:0] ROW0_P2 = C_P2;
   localparam logic [11:0] EDGE_C  = C_BLACK;
`endif

   logic        clock;
   logic        reset;
   logic [18:0] ram_address;
   logic [1:0]  ram_read_data;
   logic        hsync;
   logic        vsync;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
   logic        blank;
   logic        frame_start;

   vga_scanout #(
      .CLK_DIV (2),
      .V_ACTIVE(VA),
      .V_FP    (VF),
      .V_SYNC  (VS),
      .V_BP    (VB)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .ram_address  (ram_address),
      .ram_read_data(ram_read_data),
      .hsync        (hsync),
      .vsync        (vsync),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .blank        (blank),
      .frame_start  (frame_start)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Framebuffer RAM model with one clock of read latency.
   logic [1:0] fb [0:76799];
   always_ff @(posedge clock) ram_read_data <= fb[ram_address];

   int n_checks = 0;
   int n_pass   = 0;
   int t        = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   task automatic go_to(input int target);
      while (t < target) begin
         @(negedge clock);
         t++;
      end
      #1;
   endtask

   function automatic int ta(input int h, input int v);
      return 2 * (800 * v + h);
   endfunction

   logic [11:0] rgb;
   assign rgb = {red, green, blue};

   int         hs_low;
   logic [18:0] exp_addr [0:5];
   logic [11:0] exp_rgb  [0:3];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 76800; i++) fb[i] = 2'b00;
      fb[0]   = 2'b01;
      fb[1]   = 2'b10;
      fb[321] = 2'b01;
      fb[322] = 2'b10;
      fb[323] = 2'b11;
      exp_addr = '{19'd0, 19'd0, 19'd1, 19'd1, 19'd2, 19'd2};
      exp_rgb  = '{ROW0_P1, ROW0_P1, ROW0_P2, ROW0_P2};

      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #1;
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_blank", 32'(blank), 32'd1);
      check("rst_rgb", 32'(rgb), 32'(C_BLACK));
      check("rst_addr", 32'(ram_address), 32'd0);
      check("rst_fs", 32'(frame_start), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      t = 0;
      #1;
      check("fs_first", 32'(frame_start), 32'd1);

      for (int p = 0; p < 6; p++) begin
         go_to(2 * p);
         check("addr_row0", 32'(ram_address), 32'(exp_addr[p]));
         go_to(2 * p + 1);
         check("fs_low", 32'(frame_start), 32'd0);
         if (p < 4) begin
            check("rgb_row0", 32'(rgb), 32'(exp_rgb[p]));
            check("blank_row0", 32'(blank), 32'd0);
         end
      end

      go_to(ta(10, 0) + 1);
      check("rgb_top_edge", 32'(rgb), 32'(EDGE_C));
      go_to(ta(640, 0));
      check("addr_hblank", 32'(ram_address), 32'd0);
      go_to(ta(640, 0) + 1);
      check("blank_hblank", 32'(blank), 32'd1);
      check("rgb_hblank", 32'(rgb), 32'(C_BLACK));
      go_to(ta(655, 0) + 1);
      check("hsync_655", 32'(hsync), 32'd1);
      go_to(ta(656, 0) + 1);
      check("hsync_656", 32'(hsync), 32'd0);
      go_to(ta(751, 0) + 1);
      check("hsync_751", 32'(hsync), 32'd0);
      go_to(ta(752, 0) + 1);
      check("hsync_752", 32'(hsync), 32'd1);

      hs_low = 0;
      for (int h = 0; h < 800; h++) begin
         go_to(ta(h, 1) + 1);
         if (!hsync) hs_low++;
      end
      check("hsync_len", 32'(hs_low), 32'd96);

      go_to(ta(0, 2));
      check("addr_v2", 32'(ram_address), 32'd320);
      go_to(ta(2, 2) + 1);
      check("rgb_p1", 32'(rgb), 32'(C_P1));
      check("blank_v2", 32'(blank), 32'd0);
      go_to(ta(3, 2) + 1);
      check("rgb_p1_dup", 32'(rgb), 32'(C_P1));
      go_to(ta(4, 2) + 1);
      check("rgb_p2", 32'(rgb), 32'(C_P2));
      go_to(ta(5, 2) + 1);
      check("rgb_p2_dup", 32'(rgb), 32'(C_P2));
      go_to(ta(6, 2) + 1);
      check("rgb_wall", 32'(rgb), 32'(C_WALL));
      go_to(ta(8, 2) + 1);
      check("rgb_empty", 32'(rgb), 32'(C_BLACK));

      go_to(ta(0, 4) + 1);
      check("rgb_left_edge", 32'(rgb), 32'(EDGE_C));
      go_to(ta(20, 4) + 1);
      check("rgb_interior", 32'(rgb), 32'(C_BLACK));
      go_to(ta(638, 4) + 1);
      check("rgb_right_edge", 32'(rgb), 32'(EDGE_C));

      go_to(ta(639, 5));
      check("addr_last", 32'(ram_address), 32'd959);
      go_to(ta(639, 5) + 1);
      check("blank_last", 32'(blank), 32'd0);
      go_to(ta(0, 6));
      check("addr_vblank", 32'(ram_address), 32'd0);
      go_to(ta(0, 6) + 1);
      check("blank_vblank", 32'(blank), 32'd1);

      go_to(ta(0, 7) + 1);
      check("vsync_v7", 32'(vsync), 32'd1);
      go_to(ta(0, 8) + 1);
      check("vsync_v8", 32'(vsync), 32'd0);
      go_to(ta(0, 9) + 1);
      check("vsync_v9", 32'(vsync), 32'd0);
      go_to(ta(0, 10) + 1);
      check("vsync_v10", 32'(vsync), 32'd1);

      go_to(FRAME_T - 1);
      check("fs_before", 32'(frame_start), 32'd0);
      go_to(FRAME_T);
      check("fs_frame1", 32'(frame_start), 32'd1);
      go_to(FRAME_T + 1);
      check("rgb_frame1", 32'(rgb), 32'(ROW0_P1));
      go_to(FRAME_T + 2);
      check("fs_after", 32'(frame_start), 32'd0);
      go_to(FRAME_T + 4);
      check("addr_frame1", 32'(ram_address), 32'd1);

      // Mid-frame reset at line 3 of frame 1.
      go_to(FRAME_T + ta(100, 3));
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #1;
      check("mrst_blank", 32'(blank), 32'd1);
      check("mrst_hsync", 32'(hsync), 32'd1);
      check("mrst_addr", 32'(ram_address), 32'd0);
      check("mrst_fs", 32'(frame_start), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      t = 0;
      #1;
      check("mrst_fs_first", 32'(frame_start), 32'd1);
      go_to(1);
      check("mrst_rgb0", 32'(rgb), 32'(ROW0_P1));
      go_to(4);
      check("mrst_addr_h2", 32'(ram_address), 32'd1);
      go_to(8);
      check("mrst_addr_h4", 32'(ram_address), 32'd2);
      go_to(FRAME_T - 2);
      check("mrst_fs_early", 32'(frame_start), 32'd0);
      go_to(FRAME_T);
      check("mrst_fs_next", 32'(frame_start), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
